// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that time-shares one SPI byte engine among N_REQ clients,
// driving per-client chip-selects with a guaranteed idle gap. Optional watchdog: SPI_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module spi_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    req_err,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_tx,
  input  logic                    eng_done,
  input  logic [DATA_W-1:0]       eng_rx,
  output logic [N_REQ-1:0]        cs_n
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LAUNCH, S_WAIT, S_RELEASE, S_GAP
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [N_REQ-1:0]    grant_q;
  logic [N_REQ-1:0]    done_q;
  logic                err_q;
  logic                start_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rsp_q;
  logic [N_REQ-1:0]    cs_q;
  logic [GAP_W-1:0]    gap_q;

  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [N_REQ-1:0]    win_oh;
  logic [IDX_W:0]      rr_sum;
  logic [IDX_W-1:0]    rr_cand;
  logic                to_hit;

  // Search starts one past the previous winner so every client gets a turn.
  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_sum = {1'b0, last_q} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(N_REQ)) rr_sum = rr_sum - (IDX_W+1)'(N_REQ);
      rr_cand = rr_sum[IDX_W-1:0];
      if (!win_found && req[rr_cand]) begin
        win_found = 1'b1;
        win_idx   = rr_cand;
      end
    end
    win_oh = N_REQ'(1) << win_idx;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q;

  // Held at zero outside WAIT, so it is clear on every entry into WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_q <= '0;
    else if (state_q != S_WAIT) to_q <= '0;
    else if (!to_hit)          to_q <= to_q + TO_W'(1);
  end

  assign to_hit = (to_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      tx_q    <= '0;
      rsp_q   <= '0;
      cs_q    <= '1;
      gap_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (|req) state_q <= S_ARB;
        S_ARB: begin
          if (win_found) begin
            grant_q <= win_oh;
            tx_q    <= req_data[int'(win_idx)*DATA_W +: DATA_W];
            last_q  <= win_idx;
            cs_q    <= ~win_oh;
            start_q <= 1'b1;
            state_q <= S_LAUNCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          // A timeout completes the transfer with rsp_data left untouched.
          if (eng_done || to_hit) begin
            if (eng_done) rsp_q <= eng_rx;
            err_q   <= ~eng_done;
            done_q  <= grant_q;
            grant_q <= '0;
            cs_q    <= '1;
            gap_q   <= GAP_W'(GAP_CYC - 1);
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE, S_GAP: begin
          // RELEASE is the first cycle of the chip-select gap.
          if (gap_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_q   <= gap_q - GAP_W'(1);
            state_q <= S_GAP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign req_done  = done_q;
  assign rsp_data  = rsp_q;
  assign req_err   = err_q;
  assign eng_start = start_q;
  assign eng_tx    = tx_q;
  assign cs_n      = cs_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: engine model plus scoreboard of expected completions.
// Build with SPI_ARB_TIMEOUT_EN defined to also exercise the watchdog path.
`timescale 1ns/1ps

module tb_spi_req_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   grant, req_done, cs_n;
  logic [W-1:0]   rsp_data, eng_tx;
  logic           req_err, eng_start;
  logic           eng_done = 1'b0;
  logic [W-1:0]   eng_rx = '0;

  always #5 clk = ~clk;

  spi_req_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
    .req_done(req_done), .rsp_data(rsp_data), .req_err(req_err), .eng_start(eng_start),
    .eng_tx(eng_tx), .eng_done(eng_done), .eng_rx(eng_rx), .cs_n(cs_n)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] tx;
    logic [W-1:0] rsp;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int done_cnt = 0, start_cnt = 0, last_start_cyc = 0, last_done_cyc = 0;
  int eng_delay = 4;
  bit eng_hang = 1'b0, tight_gap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [W-1:0] tx, input logic [W-1:0] rsp, input logic err);
    exp_t e;
    e.idx = idx; e.tx = tx; e.rsp = rsp; e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int b = 0;
    while (done_cnt < target && b < budget) begin @(posedge clk); #1; b++; end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int b = 0;
    while (start_cnt < target && b < budget) begin @(posedge clk); #1; b++; end
    check(tag, start_cnt, target);
  endtask

  always @(posedge clk) cyc++;

  // SPI engine model: answers with the bitwise inverse of the byte it was given.
  initial begin
    bit           busy = 1'b0;
    int           ecnt = 0;
    logic [W-1:0] edata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 1'b0; eng_done = 1'b0;
      end else begin
        eng_done = 1'b0;
        if (busy) begin
          if (ecnt == 0) begin eng_done = 1'b1; eng_rx = edata; busy = 1'b0; end
          else ecnt--;
        end
        if (eng_start && !eng_hang) begin
          busy = 1'b1; ecnt = eng_delay - 1; edata = ~eng_tx;
        end
      end
    end
  end

  // Monitor: invariants, gap length, and scoreboard matching on start/done.
  initial begin
    logic [N-1:0] prev_cs = '1;
    int           hi_cnt = 0;
    bit           seen_xfer = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_xfer = 1'b0; hi_cnt = 0; prev_cs = '1;
      end else begin
        check("grant_onehot0", $onehot0(grant), 1);
        check("cs_single_low", $onehot0(~cs_n), 1);
        if (cs_n == '1) hi_cnt++;
        else begin
          if (prev_cs == '1 && seen_xfer) begin
            check("gap_min", hi_cnt >= GAP, 1);
            if (tight_gap) check("gap_exact", hi_cnt, GAP + 2);
          end
          hi_cnt = 0;
        end
        if (eng_start) begin
          start_cnt++;
          last_start_cyc = cyc;
          check("start_pending", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            check("start_grant", grant, 1 << sb[0].idx);
            check("start_tx", eng_tx, sb[0].tx);
            check("start_cs", cs_n ^ grant, {N{1'b1}});
          end
        end
        if (req_done != '0) begin
          done_cnt++;
          last_done_cyc = cyc;
          seen_xfer = 1'b1;
          check("done_pending", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("done_onehot", req_done, 1 << mon_e.idx);
            check("done_rsp", rsp_data, mon_e.rsp);
            check("done_err", req_err, mon_e.err);
            check("done_cs_high", cs_n, {N{1'b1}});
            check("done_grant_zero", grant, 0);
          end
        end
        prev_cs = cs_n;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_start", eng_start, 0);
    check("rst_eng_tx", eng_tx, 0);
    check("rst_rsp", rsp_data, 0);
    check("rst_done", req_done, 0);
    check("rst_err", req_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // Single request from client 1, engine answers after 64 cycles
    eng_delay = 64;
    req_data[1*W +: W] = 8'hA3;
    push(1, 8'hA3, 8'h5C, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    check("lat_c0_cs", cs_n, 4'hF);
    @(negedge clk);
    check("lat_c1_cs", cs_n, 4'hF);
    check("lat_c1_grant", grant, 0);
    @(negedge clk);
    check("lat_c2_cs", cs_n, 4'b1101);
    check("lat_c2_start", eng_start, 1);
    check("lat_c2_grant", grant, 4'b0010);
    check("lat_c2_tx", eng_tx, 8'hA3);
    @(posedge clk); #1;
    wait_dones(1, 200, "single_done");
    req = '0;
    check("single_latency", last_done_cyc - last_start_cyc, 65);
    tick(10);
    @(negedge clk);
    check("single_rsp_hold", rsp_data, 8'h5C);
    check("single_cs_idle", cs_n, 4'hF);
    check("single_grant_idle", grant, 0);

    // req_data change during WAIT must not disturb the transfer
    @(posedge clk); #1;
    eng_delay = 20;
    req_data[2*W +: W] = 8'h11;
    push(2, 8'h11, 8'hEE, 1'b0);
    req = 4'b0100;
    wait_starts(2, 20, "data_start");
    tick(5);
    req_data[2*W +: W] = 8'hFF;
    tick(3);
    @(negedge clk);
    check("data_tx_hold", eng_tx, 8'h11);
    check("data_cs", cs_n, 4'b1011);
    @(posedge clk); #1;
    wait_dones(2, 100, "data_done");
    req = '0;
    tick(12);

    // One-cycle req pulse from client 3 during another transfer gets no grant
    req_data[0 +: W] = 8'h5A;
    push(0, 8'h5A, 8'hA5, 1'b0);
    req = 4'b0001;
    wait_starts(3, 20, "wd_start");
    tick(4);
    req[3] = 1'b1;
    tick(1);
    req[3] = 1'b0;
    wait_dones(3, 100, "wd_done");
    req = '0;
    tick(20);
    @(negedge clk);
    check("wd_no_start", start_cnt, 3);
    check("wd_grant_idle", grant, 0);

    // Asynchronous reset in the middle of WAIT
    @(posedge clk); #1;
    eng_delay = 40;
    req_data[1*W +: W] = 8'h77;
    push(1, 8'h77, 8'h88, 1'b0);
    req = 4'b0010;
    wait_starts(4, 20, "rst_mid_start");
    tick(5);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs", cs_n, 4'hF);
    check("rst_mid_grant", grant, 0);
    check("rst_mid_tx", eng_tx, 0);
    check("rst_mid_rsp", rsp_data, 0);
    sb.delete();
    req = '0;
    tick(3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(50);
    check("rst_mid_no_done", done_cnt, 3);

    // Contention: all four held high -> order 0,1,2,3,0 with tight gaps
    eng_delay = 3;
    tight_gap = 1'b1;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    push(0, 8'h10, 8'hEF, 1'b0);
    push(1, 8'h20, 8'hDF, 1'b0);
    push(2, 8'h30, 8'hCF, 1'b0);
    push(3, 8'h40, 8'hBF, 1'b0);
    push(0, 8'h10, 8'hEF, 1'b0);
    req = 4'b1111;
    wait_dones(8, 400, "cont_done");
    req = '0;
    tick(15);
    tight_gap = 1'b0;
    @(negedge clk);
    check("cont_starts", start_cnt, 9);
    check("cont_grant_idle", grant, 0);
    check("cont_sb_empty", sb.size(), 0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Engine never answers: watchdog completes with req_err and unchanged rsp_data
    @(posedge clk); #1;
    eng_hang = 1'b1;
    req_data[0 +: W] = 8'h42;
    push(0, 8'h42, 8'hEF, 1'b1);
    req = 4'b0001;
    wait_dones(9, 100, "tmo_done");
    req = '0;
    check("tmo_latency", last_done_cyc - last_start_cyc, TMO + 1);
    eng_hang = 1'b0;
    tick(12);
    @(negedge clk);
    check("tmo_grant_idle", grant, 0);
    check("tmo_cs_idle", cs_n, 4'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter and sequencer that shares one SPI byte engine among `N_REQ` requesters. It grants one requester at a time and drives that requester's chip-select. It launches a single-byte transfer on the engine, waits for completion, returns the received byte, and enforces a chip-select idle gap before the next grant. It sits between client blocks (sensor pollers, config loaders) and the SPI shift engine, which owns `sclk`/`mosi`/`miso`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters and chip-selects (2..8).
- `DATA_W`, 8: transfer width in bits.
- `GAP_CYC`, 4: minimum `clk` cycles with all `cs_n` high between transactions (≥1).
- `TIMEOUT_CYC`, 256: watchdog limit in `WAIT`; used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `req`  in  N_REQ  per-requester transfer request; level, held until `req_done`.
- `req_data`  in  N_REQ*DATA_W  per-requester TX byte; slice i = `[i*DATA_W +: DATA_W]`.
- `grant`  out  N_REQ  one-hot current owner; all-zero when idle.
- `req_done`  out  N_REQ  one-cycle completion pulse to the owner.
- `rsp_data`  out  DATA_W  received byte; valid in the `req_done` cycle and held until the next completion.
- `req_err`  out  1  owner's transfer aborted by timeout; pulses with `req_done`.
- `eng_start`  out  1  one-cycle start pulse to the SPI engine.
- `eng_tx`  out  DATA_W  byte to shift out; stable from `eng_start` until `eng_done`.
- `eng_done`  in  1  one-cycle pulse from the engine at end of transfer.
- `eng_rx`  in  DATA_W  engine's received byte; valid while `eng_done`=1.
- `cs_n`  out  N_REQ  active-low chip-selects; bit i belongs to requester i.

## Operation
- Reset values:
  - `grant`=0, `req_done`=0, `req_err`=0, `eng_start`=0.
  - `eng_tx`=0, `rsp_data`=0, `cs_n`=all ones.
  - Priority pointer `last`=N_REQ-1, so requester 0 has top priority after reset.
  - State=`IDLE`.
- States:
  - `IDLE`: if any `req` bit is set, go to `ARB`.
  - `ARB`: pick the first set `req` bit searching `last+1, last+2, …` modulo N_REQ. Register the one-hot `grant`, capture `req_data` slice into `eng_tx`, set `last`=winner, go to `LAUNCH`. If `req` went all-zero, return to `IDLE` with no grant.
  - `LAUNCH`: `cs_n[winner]`=0, `eng_start`=1 for exactly this cycle, go to `WAIT`.
  - `WAIT`: hold `cs_n[winner]` low. On `eng_done`, capture `eng_rx` into `rsp_data` and go to `RELEASE`.
  - `RELEASE`:
    - `req_done[winner]`=1 for one cycle.
    - `cs_n` all high, `grant`=0.
    - Load the gap counter with GAP_CYC-1, go to `GAP`.
  - `GAP`: decrement to 0, then go to `IDLE`. Requests arriving here wait.
- Arbitration facts:
  - Round-robin is fair. A continuously requesting client waits at most N_REQ-1 transactions.
  - `req_data` is sampled only in `ARB`. Later changes do not affect the transfer in flight.
  - Deasserting `req` after grant does not abort; the transfer completes and `req_done` still pulses.
  - A requester must drop `req` in the cycle after `req_done` if it wants no further transfer. A `req` still high at the next `ARB` is treated as a new request.
- Invariants:
  - At most one `cs_n` bit is low at any time.
  - `grant` is one-hot or zero.
  - `eng_start` never asserts outside `LAUNCH`.
  - `eng_done` outside `WAIT` is ignored.

## Timing
- Request-to-start latency from idle: `req` rises at cycle 0 → `ARB` at cycle 1 → `grant` and `eng_tx` valid and `LAUNCH` (`cs_n` low, `eng_start`) at cycle 2.
- `eng_done` at cycle k → `req_done`, `rsp_data` valid, `cs_n` high at k+1.
- Earliest next `cs_n` low is k+1+GAP_CYC+2.
- Simultaneous `eng_done` and new `req`: the new request is served after the gap under round-robin order.
- Asynchronous `rst_n` assertion mid-transfer:
  - All outputs go immediately to their reset values, with `cs_n` high.
  - The in-flight transfer is dropped with no `req_done`.
  - The engine must be reset by the same `rst_n`.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs in `WAIT`.
  - If `eng_done` is not seen within TIMEOUT_CYC cycles, go to `RELEASE` with `rsp_data` unchanged and `req_err`=1 alongside `req_done`.
  - The counter clears on entering `WAIT`.
- Not defined: no counter and `req_err` tied 0. `WAIT` waits indefinitely for `eng_done`.

## Test plan
- Single request: after reset, `req`=4'b0010, `req_data[1]`=8'hA3; engine model returns 8'h5C after 64 cycles → `cs_n`=4'b1101 from cycle 2, one `eng_start` with `eng_tx`=8'hA3, `req_done`=4'b0010 pulse with `rsp_data`=8'h5C, `cs_n` all high after.
- Contention: all four `req` held high → grant order 0,1,2,3,0; `cs_n` high for ≥GAP_CYC=4 cycles between transfers; never two `cs_n` low.
- Mid-transfer data change: change `req_data[2]` to 8'hFF during `WAIT` → `eng_tx` stays at the captured value, e.g. 8'h11.
- Request withdrawn: pulse `req[3]` for one cycle while another transfer is active → no grant to 3.
- Reset mid-transfer: drop `rst_n` during `WAIT` → `cs_n`=4'hF and `grant`=0 immediately; after release, requester 0 wins first.
- With `SPI_ARB_TIMEOUT_EN` and TIMEOUT_CYC=16, engine never pulses `eng_done` → `req_done` and `req_err` pulse together 17 cycles after `eng_start`; the arbiter returns to `IDLE`.
